mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter IO_BASE SHALL default to 32'h30000: lowest address treated as memory-mapped I/O.
REQ-002 Parameter ADDR_W SHALL default to 32: width of all address ports.
REQ-003 clk_in  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 rdy_in  input  1  SHALL be the global ready: low freezes all state.
REQ-006 clear_in  input  1  SHALL be the pipeline flush from branch mispredict.
REQ-007 if_req_in/if_addr_in  input  1/ADDR_W  SHALL carry the fetch request and address (always 4 bytes).
REQ-008 if_done_out/if_data_out  output  1/32  SHALL return the fetch completion pulse and word.
REQ-009 lsb_req_in/lsb_we_in/lsb_size_in  input  1/1/2  SHALL carry the LSB request, write enable and size (00=1B, 01=2B, 1x=4B).
REQ-010 lsb_addr_in/lsb_wdata_in  input  ADDR_W/32  SHALL carry the LSB address and store data.
REQ-011 lsb_done_out/lsb_rdata_out  output  1/32  SHALL return the LSB completion pulse and zero-extended load data.
REQ-012 mem_din  input  8  SHALL be RAM read data, valid one cycle after its address.
REQ-013 mem_dout/mem_a/mem_wr  output  8/ADDR_W/1  SHALL drive the byte-wide RAM port.
REQ-014 io_buffer_full  input  1  SHALL indicate the UART transmit buffer is full.

Function
REQ-015 FSM states SHALL be IDLE, READ, WRITE; requests are sampled only in IDLE with if_done_out and lsb_done_out both low.
REQ-016 Requesters SHALL hold req and operands stable until their done pulse, and drop req the cycle after done.
REQ-017 Grant cycle G (IDLE, request sampled): for byte i of n, mem_a SHALL be addr+i during cycle G+1+i, little-endian.
REQ-018 Reads: mem_wr SHALL be 0; byte i is captured from mem_din at end of G+2+i; done and data SHALL be high/valid for exactly cycle G+n+2, then IDLE.
REQ-019 Writes: mem_wr=1 and mem_dout=wdata[8i+7:8i] SHALL be driven during G+1+i; lsb_done_out SHALL pulse in G+n+1.
REQ-020 Write with addr>=IO_BASE and io_buffer_full high SHALL hold mem_wr=0 and the current byte index until io_buffer_full is low.
REQ-021 Outside active byte cycles, mem_wr SHALL be 0 and mem_a SHALL be 0.
REQ-022 clear_in high during an IF transfer SHALL abort it: IDLE next cycle, no if_done_out; LSB transfers SHALL be unaffected.
REQ-023 clear_in high in IDLE SHALL block granting IF that cycle.
REQ-024 rdy_in low SHALL freeze state, counters and outputs except mem_wr, which SHALL be forced 0.
REQ-025 Byte counter wrap: addr+i SHALL wrap modulo 2^ADDR_W.

Reset
REQ-026 rst_in high SHALL force IDLE, counters 0, all done outputs 0, data outputs 0, mem_a 0, mem_dout 0, mem_wr 0 at the next edge, aborting any transfer without a done pulse.
REQ-027 rst_in SHALL take priority over rdy_in and clear_in.

Configuration
REQ-028 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not served in the most recent grant (initial after reset: LSB).
REQ-029 Without MEM_ARB_RR_EN, simultaneous requests SHALL always be granted to LSB.

Structure
REQ-030 Package riscv_mem_pkg SHALL hold the state enum, size encoding constants and IO_BASE default.
REQ-031 The block SHALL be a single module; no sub-module is required.

Verification
REQ-032 IF read 0x1000, RAM bytes 13,00,00,00 -> if_done_out in G+6, if_data_out=32'h00000013.
REQ-033 LSB 2B store 0x2002 wdata 32'hABCD -> mem_wr with (0x2002,CD),(0x2003,AB) in G+1,G+2; lsb_done_out in G+3.
REQ-034 Store 1B to 0x30000 with io_buffer_full high 5 cycles -> mem_wr stays 0 those cycles, write issues after, done 1 cycle later.
REQ-035 IF and LSB load asserted together twice -> fixed: LSB,LSB; with MEM_ARB_RR_EN: LSB then IF.
REQ-036 clear_in at G+3 of IF read -> no if_done_out, IDLE at G+4, pending LSB granted next.
REQ-037 rst_in mid-write at G+2 -> mem_wr 0 next cycle, no done, outputs all 0.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared state encoding, access-size constants and I/O base for mem_arbiter.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } arb_state_e;

    localparam logic [1:0]  SIZE_B = 2'b00;
    localparam logic [1:0]  SIZE_H = 2'b01;
    localparam logic [1:0]  SIZE_W = 2'b10;
    localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

    // Any size with bit 1 set is a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        if ((size & SIZE_W) != 2'b00) return 3'd4;
        if (size == SIZE_H)           return 3'd2;
        return 3'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store traffic onto one byte-wide RAM port.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise LSB always wins.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_done_out,
    output logic [31:0]       if_data_out,
    input  logic              lsb_req_in,
    input  logic              lsb_we_in,
    input  logic [1:0]        lsb_size_in,
    input  logic [ADDR_W-1:0] lsb_addr_in,
    input  logic [31:0]       lsb_wdata_in,
    output logic              lsb_done_out,
    output logic [31:0]       lsb_rdata_out,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

`ifdef MEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_e        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              own_lsb_q, own_lsb_d;
    logic              last_lsb_q, last_lsb_d;
    logic              if_done_q, if_done_d;
    logic              lsb_done_q, lsb_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       lsb_data_q, lsb_data_d;

    logic              if_ok;
    logic              grant_lsb;
    logic              stall;
    logic [1:0]        cap_idx;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            own_lsb_q  <= 1'b0;
            last_lsb_q <= 1'b0;
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            if_data_q  <= '0;
            lsb_data_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            own_lsb_q  <= own_lsb_d;
            last_lsb_q <= last_lsb_d;
            if_done_q  <= if_done_d;
            lsb_done_q <= lsb_done_d;
            if_data_q  <= if_data_d;
            lsb_data_q <= lsb_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        own_lsb_d  = own_lsb_q;
        last_lsb_d = last_lsb_q;
        if_done_d  = 1'b0;
        lsb_done_d = 1'b0;
        if_data_d  = if_data_q;
        lsb_data_d = lsb_data_q;
        if_ok      = 1'b0;
        grant_lsb  = 1'b0;
        stall      = 1'b0;
        cap_idx    = cnt_q[1:0] - 2'd1;
        mem_a      = '0;
        mem_dout   = '0;
        mem_wr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if_ok = if_req_in && !clear_in;
                // The done-pulse cycle is still IDLE; requesters have not yet dropped req.
                if (!if_done_q && !lsb_done_q) begin
                    grant_lsb = lsb_req_in && (!if_ok || !RR_EN || !last_lsb_q);
                    if (grant_lsb) begin
                        own_lsb_d  = 1'b1;
                        last_lsb_d = 1'b1;
                        base_d     = lsb_addr_in;
                        n_d        = size_bytes(lsb_size_in);
                        wdata_d    = lsb_wdata_in;
                        cnt_d      = '0;
                        state_d    = lsb_we_in ? ST_WRITE : ST_READ;
                        if (!lsb_we_in) lsb_data_d = '0;
                    end else if (if_ok) begin
                        own_lsb_d  = 1'b0;
                        last_lsb_d = 1'b0;
                        base_d     = if_addr_in;
                        n_d        = 3'd4;
                        cnt_d      = '0;
                        state_d    = ST_READ;
                        if_data_d  = '0;
                    end
                end
            end

            ST_READ: begin
                // cnt_q counts address cycles; byte cnt_q-1 arrives on mem_din one cycle later.
                if (cnt_q < n_q) mem_a = base_q + ADDR_W'(cnt_q);
                if (clear_in && !own_lsb_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        if (own_lsb_q) lsb_data_d[{cap_idx, 3'b000} +: 8] = mem_din;
                        else           if_data_d[{cap_idx, 3'b000} +: 8]  = mem_din;
                    end
                    if (cnt_q == n_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (own_lsb_q) lsb_done_d = 1'b1;
                        else           if_done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_WRITE: begin
                stall    = (base_q >= IO_BASE) && io_buffer_full;
                mem_a    = base_q + ADDR_W'(cnt_q);
                mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in && !stall;
                if (!stall) begin
                    if (cnt_q == n_q - 3'd1) begin
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                        lsb_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign if_done_out   = if_done_q;
    assign if_data_out   = if_data_q;
    assign lsb_done_out  = lsb_done_q;
    assign lsb_rdata_out = lsb_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a cycle-relative transaction model checked every cycle.
module tb_mem_arbiter;

    localparam logic [31:0] TB_IO_BASE = 32'h0003_0000;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int M_NONE = 0, M_READ = 1, M_WRITE = 2;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, clear_in;
    logic        if_req_in, if_done_out;
    logic [31:0] if_addr_in, if_data_out;
    logic        lsb_req_in, lsb_we_in, lsb_done_out;
    logic [1:0]  lsb_size_in;
    logic [31:0] lsb_addr_in, lsb_wdata_in, lsb_rdata_out;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .lsb_req_in(lsb_req_in), .lsb_we_in(lsb_we_in), .lsb_size_in(lsb_size_in),
        .lsb_addr_in(lsb_addr_in), .lsb_wdata_in(lsb_wdata_in),
        .lsb_done_out(lsb_done_out), .lsb_rdata_out(lsb_rdata_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int if_done_cnt = 0;
    int lsb_done_cnt = 0;

    typedef struct {int c; logic [31:0] a; logic [7:0] d;} wr_t;
    wr_t wr_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte RAM with one-cycle registered read, plus a preload port for the bench.
    logic [7:0]  ram [0:65535];
    logic        preload_en;
    logic [15:0] preload_addr;
    logic [7:0]  preload_data;
    always @(posedge clk) begin
        if (preload_en)  ram[preload_addr] <= preload_data;
        else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: expectations derived from cycles elapsed since the grant.
    int          m_mode = M_NONE, m_rel = 0, m_j = 0, m_n = 0;
    logic        m_lsb = 1'b0, m_we = 1'b0, m_last_lsb = 1'b0, m_chk = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;

    always @(negedge clk) begin : model_blk
        logic [31:0] e_a, e_dout, e_data, idx;
        logic        e_wr, e_ifd, e_lsbd, stall, if_ok;
        e_a = '0; e_dout = '0; e_data = '0; e_wr = 1'b0; e_ifd = 1'b0; e_lsbd = 1'b0;
        stall = (m_addr >= TB_IO_BASE) && io_buffer_full;
        if (m_mode == M_READ) begin
            if (m_rel >= 1 && m_rel <= m_n) e_a = m_addr + 32'(m_rel - 1);
            if (m_rel == m_n + 2) begin
                for (int i = 0; i < m_n; i++) begin
                    idx = m_addr + 32'(i);
                    e_data = e_data | (32'(ram[idx[15:0]]) << (8 * i));
                end
                if (m_lsb) e_lsbd = 1'b1; else e_ifd = 1'b1;
            end
        end else if (m_mode == M_WRITE) begin
            if (m_j < m_n) begin
                e_a    = m_addr + 32'(m_j);
                e_wr   = !stall && rdy_in;
                e_dout = (m_wdata >> (8 * m_j)) & 32'hFF;
            end else begin
                e_lsbd = 1'b1;
            end
        end

        if (m_chk) begin
            check("mem_a", mem_a, e_a);
            check("mem_wr", mem_wr, e_wr);
            if (e_wr) check("mem_dout", mem_dout, e_dout);
            check("if_done_out", if_done_out, e_ifd);
            check("lsb_done_out", lsb_done_out, e_lsbd);
            if (e_ifd) check("if_data_out", if_data_out, e_data);
            if (e_lsbd && !m_we) check("lsb_rdata_out", lsb_rdata_out, e_data);
        end
        if (mem_wr) wr_log.push_back('{cyc, mem_a, mem_dout});
        if (if_done_out) if_done_cnt++;
        if (lsb_done_out) lsb_done_cnt++;

        if (rst_in) begin
            m_mode = M_NONE; m_last_lsb = 1'b0; m_chk = 1'b1;
        end else if (rdy_in) begin
            if (m_mode == M_READ) begin
                if (!m_lsb && clear_in && m_rel <= m_n + 1) m_mode = M_NONE;
                else if (m_rel == m_n + 2) m_mode = M_NONE;
                else m_rel++;
            end else if (m_mode == M_WRITE) begin
                if (m_j == m_n) m_mode = M_NONE;
                else if (!stall) m_j++;
            end else begin
                if_ok = if_req_in && !clear_in;
                if (lsb_req_in && (!if_ok || !RR || !m_last_lsb)) begin
                    m_mode = lsb_we_in ? M_WRITE : M_READ;
                    m_lsb = 1'b1; m_we = lsb_we_in; m_addr = lsb_addr_in; m_wdata = lsb_wdata_in;
                    m_n = (lsb_size_in == 2'b00) ? 1 : (lsb_size_in == 2'b01) ? 2 : 4;
                    m_rel = 1; m_j = 0; m_last_lsb = 1'b1;
                end else if (if_ok) begin
                    m_mode = M_READ; m_lsb = 1'b0; m_we = 1'b0; m_addr = if_addr_in;
                    m_n = 4; m_rel = 1; m_j = 0; m_last_lsb = 1'b0;
                end
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        preload_addr = a; preload_data = d; preload_en = 1'b1;
        @(posedge clk); #1;
        preload_en = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] addr, output int g, output int d);
        @(posedge clk); #1;
        if_addr_in = addr; if_req_in = 1'b1; g = cyc; d = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (if_done_out) begin d = cyc; break; end
        end
        if (d < 0) begin
            checks++; errors++;
            $display("FAIL if_timeout: no if_done_out within 40 cycles, expected one");
        end
        @(posedge clk); #1;
        if_req_in = 1'b0;
    endtask

    task automatic do_lsb(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, output int g, output int d,
                          output logic [31:0] rdata);
        @(posedge clk); #1;
        lsb_we_in = we; lsb_size_in = size; lsb_addr_in = addr; lsb_wdata_in = wdata;
        lsb_req_in = 1'b1; g = cyc; d = -1; rdata = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (lsb_done_out) begin d = cyc; rdata = lsb_rdata_out; break; end
        end
        if (d < 0) begin
            checks++; errors++;
            $display("FAIL lsb_timeout: no lsb_done_out within 40 cycles, expected one");
        end
        @(posedge clk); #1;
        lsb_req_in = 1'b0;
    endtask

    int g, d, g2, d2, snap;
    logic [31:0] rd;

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        if_req_in = 1'b0; if_addr_in = '0; lsb_req_in = 1'b0; lsb_we_in = 1'b0;
        lsb_size_in = '0; lsb_addr_in = '0; lsb_wdata_in = '0; preload_en = 1'b0;
        preload_addr = '0; preload_data = '0;
        preload(16'h1000, 8'h13); preload(16'h1001, 8'h00);
        preload(16'h1002, 8'h00); preload(16'h1003, 8'h00);
        preload(16'hFFFF, 8'h5A);
        @(negedge clk);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_if_done", if_done_out, 0);
        check("rst_lsb_rdata", lsb_rdata_out, 0);
        @(posedge clk); #1;
        rst_in = 1'b0;

        // Instruction fetch of a 4-byte word.
        do_if(32'h1000, g, d);
        check("if_done_cycle", d - g, 6);
        check("if_data", if_data_out, 32'h0000_0013);

        // Halfword store below the I/O window: buffer-full must not stall it.
        wr_log.delete();
        io_buffer_full = 1'b1;
        do_lsb(1'b1, 2'b01, 32'h2002, 32'h0000_ABCD, g, d, rd);
        io_buffer_full = 1'b0;
        check("st_h_count", wr_log.size(), 2);
        if (wr_log.size() >= 2) begin
            check("st_h_b0", {32'(wr_log[0].c - g), wr_log[0].a, wr_log[0].d}, {32'd1, 32'h2002, 8'hCD});
            check("st_h_b1", {32'(wr_log[1].c - g), wr_log[1].a, wr_log[1].d}, {32'd2, 32'h2003, 8'hAB});
        end
        check("st_h_done", d - g, 3);

        // Byte load is zero-extended.
        do_lsb(1'b0, 2'b00, 32'h2003, 32'h0, g, d, rd);
        check("ld_b_data", rd, 32'h0000_00AB);
        check("ld_b_done", d - g, 3);

        // I/O store held off for five buffer-full cycles.
        wr_log.delete();
        fork
            do_lsb(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041, g, d, rd);
            begin
                @(posedge clk); #1; io_buffer_full = 1'b1;
                repeat (6) @(posedge clk);
                #1; io_buffer_full = 1'b0;
            end
        join
        check("io_wr_count", wr_log.size(), 1);
        if (wr_log.size() >= 1) check("io_wr_cycle", wr_log[0].c - g, 6);
        check("io_done", d - g, 7);

        // Halfword load across the top of the address space.
        do_lsb(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, g, d, rd);
        check("wrap_data", rd, 32'h0000_415A);
        check("wrap_done", d - g, 4);

        // Word store with ready low for two cycles.
        wr_log.delete();
        fork
            do_lsb(1'b1, 2'b10, 32'h0000_0100, 32'h0102_0304, g, d, rd);
            begin
                @(posedge clk); #1;
                repeat (2) @(posedge clk);
                #1; rdy_in = 1'b0;
                repeat (2) @(posedge clk);
                #1; rdy_in = 1'b1;
            end
        join
        check("rdy_wr_count", wr_log.size(), 4);
        check("rdy_done", d - g, 7);

        // Flush aborts the fetch; the waiting load goes next.
        snap = if_done_cnt;
        fork
            begin
                @(posedge clk); #1;
                if_addr_in = 32'h1000; if_req_in = 1'b1; g = cyc;
                repeat (3) @(posedge clk);
                #1; clear_in = 1'b1;
                @(posedge clk); #1;
                clear_in = 1'b0; if_req_in = 1'b0;
            end
            begin
                @(posedge clk);
                do_lsb(1'b0, 2'b00, 32'h2002, 32'h0, g2, d2, rd);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("clr_no_if_done", if_done_cnt - snap, 0);
        check("clr_lsb_done", d2 - g, 7);
        check("clr_lsb_data", rd, 32'h0000_00CD);

        // Reset in the middle of a word store.
        snap = lsb_done_cnt;
        @(posedge clk); #1;
        lsb_we_in = 1'b1; lsb_size_in = 2'b10; lsb_addr_in = 32'h400;
        lsb_wdata_in = 32'hDEAD_BEEF; lsb_req_in = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0; lsb_req_in = 1'b0;
        @(negedge clk);
        check("mrst_mem_wr", mem_wr, 0);
        check("mrst_mem_a", mem_a, 0);
        check("mrst_mem_dout", mem_dout, 0);
        check("mrst_if_data", if_data_out, 0);
        check("mrst_lsb_rdata", lsb_rdata_out, 0);
        repeat (4) @(posedge clk);
        #1;
        check("mrst_no_done", lsb_done_cnt - snap, 0);

        // Two collisions; a lone LSB access sits between them.
        fork
            do_if(32'h1000, g, d);
            do_lsb(1'b0, 2'b00, 32'h2003, 32'h0, g2, d2, rd);
        join
        check("arb1_lsb_first", d2 < d, 1);
        check("arb1_lsb_done", d2 - g2, 3);
        check("arb1_if_done", d - g, 10);
        do_lsb(1'b0, 2'b00, 32'h2003, 32'h0, g, d, rd);
        fork
            do_if(32'h1000, g, d);
            do_lsb(1'b0, 2'b00, 32'h2003, 32'h0, g2, d2, rd);
        join
        check("arb2_lsb_first", d2 < d, !RR);
        check("arb2_if_done", d - g, RR ? 6 : 10);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
